// File: rtl/reglist_seq_if.sv
// Handshake/bus bundle for the LDM/STM register-list sequencer.
// The abort ports exist only when REGLIST_SEQ_ABORT_EN is defined.
interface reglist_seq_if #(
  parameter int BITWIDTH = 32
);
  logic                start;
  logic [15:0]         reglist;
  logic [BITWIDTH-1:0] base;
  logic                up;
  logic                pre;
  logic                busy;
  logic [3:0]          addr;
  logic [BITWIDTH-1:0] mem_addr;
  logic                xfer_valid;
  logic                xfer_ready;
  logic                last;
  logic                done;
  logic [BITWIDTH-1:0] wb_addr;
  logic [4:0]          count;
`ifdef REGLIST_SEQ_ABORT_EN
  logic                abort;
  logic                aborted;

  modport master (
    output start, reglist, base, up, pre, xfer_ready, abort,
    input  busy, addr, mem_addr, xfer_valid, last, done, wb_addr, count, aborted
  );
  modport slave (
    input  start, reglist, base, up, pre, xfer_ready, abort,
    output busy, addr, mem_addr, xfer_valid, last, done, wb_addr, count, aborted
  );
`else
  modport master (
    output start, reglist, base, up, pre, xfer_ready,
    input  busy, addr, mem_addr, xfer_valid, last, done, wb_addr, count
  );
  modport slave (
    input  start, reglist, base, up, pre, xfer_ready,
    output busy, addr, mem_addr, xfer_valid, last, done, wb_addr, count
  );
`endif
endinterface

// File: rtl/reglist_seq.sv
// Register-list sequencer: walks a 16-bit list lowest-first, one register per beat,
// producing read-mux select, beat address and writeback base. Optional: REGLIST_SEQ_ABORT_EN.
module reglist_seq #(
  parameter int BITWIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  reglist_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DN} state_t;

  state_t              state, state_nxt;
  logic [15:0]         mask;
  logic [BITWIDTH-1:0] mem_addr_q;
  logic [BITWIDTH-1:0] wb_addr_q;
  logic [4:0]          count_q;
  logic [4:0]          pc;
  logic [BITWIDTH-1:0] cnt4;
  logic [BITWIDTH-1:0] start_addr;
  logic [BITWIDTH-1:0] wb_nxt;
  logic                run;
  logic                hs;
  logic                last_int;
  logic                abort_req;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  assign run      = (state == RUN);
  assign hs       = run && bus.xfer_ready;
  assign last_int = run && ((mask & (mask - 16'd1)) == 16'd0);

`ifdef REGLIST_SEQ_ABORT_EN
  assign abort_req = run && bus.abort;
  logic aborted_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= abort_req;
  end
  assign bus.aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // Start-address and writeback arithmetic, evaluated from the START-cycle inputs
  always_comb begin
    pc   = popcount16(bus.reglist);
    cnt4 = {{(BITWIDTH-7){1'b0}}, pc, 2'b00};
    case ({bus.up, bus.pre})
      2'b10:   start_addr = bus.base;
      2'b11:   start_addr = bus.base + BITWIDTH'(4);
      2'b00:   start_addr = bus.base - cnt4 + BITWIDTH'(4);
      default: start_addr = bus.base - cnt4;
    endcase
    wb_nxt = bus.up ? (bus.base + cnt4) : (bus.base - cnt4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.reglist != 16'd0) ? RUN : DN;
      RUN:  if (abort_req || (hs && last_int)) state_nxt = DN;
      DN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask       <= '0;
      mem_addr_q <= '0;
      wb_addr_q  <= '0;
      count_q    <= '0;
    end else if (state == IDLE && bus.start) begin
      mask       <= bus.reglist;
      mem_addr_q <= start_addr;
      wb_addr_q  <= wb_nxt;
      count_q    <= pc;
    end else if (abort_req) begin
      mask       <= '0;
    end else if (hs) begin
      mask       <= mask & (mask - 16'd1);
      mem_addr_q <= mem_addr_q + BITWIDTH'(4);
    end
  end

  // Outputs decoded from registered state only
  assign bus.busy       = (state != IDLE);
  assign bus.xfer_valid = run;
  assign bus.addr       = run ? lowest_idx(mask) : 4'd0;
  assign bus.mem_addr   = run ? mem_addr_q : '0;
  assign bus.last       = last_int;
  assign bus.done       = (state == DN);
  assign bus.wb_addr    = wb_addr_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_reglist_seq.sv
// Directed self-checking bench for reglist_seq; abort steps run when REGLIST_SEQ_ABORT_EN is defined.
module tb_reglist_seq;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  reglist_seq_if #(.BITWIDTH(32)) bus ();

  reglist_seq #(.BITWIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_op(input logic [15:0] rl, input logic [31:0] b, input logic u, input logic p);
    bus.start   = 1'b1;
    bus.reglist = rl;
    bus.base    = b;
    bus.up      = u;
    bus.pre     = p;
    tick();
    bus.start   = 1'b0;
    bus.reglist = 16'($urandom);
    bus.base    = $urandom;
    bus.up      = 1'($urandom);
    bus.pre     = 1'($urandom);
  endtask

  task automatic beat(input string tag, input logic [3:0] a, input logic [31:0] m, input logic l);
    check({tag, "_valid"}, {31'd0, bus.xfer_valid}, 32'd1);
    check({tag, "_addr"},  {28'd0, bus.addr}, {28'd0, a});
    check({tag, "_mem"},   bus.mem_addr, m);
    check({tag, "_last"},  {31'd0, bus.last}, {31'd0, l});
    tick();
  endtask

  task automatic finish_op(input string tag, input logic [31:0] wb, input logic [4:0] cnt);
    check({tag, "_done"},  {31'd0, bus.done}, 32'd1);
    check({tag, "_nvld"},  {31'd0, bus.xfer_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd1);
    check({tag, "_wb"},    bus.wb_addr, wb);
    check({tag, "_count"}, {27'd0, bus.count}, {27'd0, cnt});
    tick();
    check({tag, "_done0"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_idle"},  {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n          = 1'b0;
    bus.start      = 1'($urandom);
    bus.reglist    = 16'($urandom);
    bus.base       = $urandom;
    bus.up         = 1'($urandom);
    bus.pre        = 1'($urandom);
    bus.xfer_ready = 1'($urandom);
`ifdef REGLIST_SEQ_ABORT_EN
    bus.abort      = 1'($urandom);
`endif
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_addr",  {28'd0, bus.addr}, 32'd0);
    check("rst_mem",   bus.mem_addr, 32'd0);
    check("rst_valid", {31'd0, bus.xfer_valid}, 32'd0);
    check("rst_last",  {31'd0, bus.last}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_wb",    bus.wb_addr, 32'd0);
    check("rst_count", {27'd0, bus.count}, 32'd0);
`ifdef REGLIST_SEQ_ABORT_EN
    check("rst_aborted", {31'd0, bus.aborted}, 32'd0);
    bus.abort = 1'b0;
`endif
    bus.start      = 1'b0;
    bus.xfer_ready = 1'b1;
    rst_n          = 1'b1;
    tick();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // IA
    start_op(16'h8005, 32'h1000, 1'b1, 1'b0);
    beat("ia_b1", 4'd0,  32'h1000, 1'b0);
    beat("ia_b2", 4'd2,  32'h1004, 1'b0);
    beat("ia_b3", 4'd15, 32'h1008, 1'b1);
    finish_op("ia", 32'h100C, 5'd3);

    // DB
    start_op(16'h00F0, 32'h2000, 1'b0, 1'b1);
    beat("db_b1", 4'd4, 32'h1FF0, 1'b0);
    beat("db_b2", 4'd5, 32'h1FF4, 1'b0);
    beat("db_b3", 4'd6, 32'h1FF8, 1'b0);
    beat("db_b4", 4'd7, 32'h1FFC, 1'b1);
    finish_op("db", 32'h1FF0, 5'd4);

    // DA and IB
    start_op(16'h0003, 32'h0100, 1'b0, 1'b0);
    beat("da_b1", 4'd0, 32'h00FC, 1'b0);
    beat("da_b2", 4'd1, 32'h0100, 1'b1);
    finish_op("da", 32'h00F8, 5'd2);
    start_op(16'h0001, 32'h0100, 1'b1, 1'b1);
    beat("ib_b1", 4'd0, 32'h0104, 1'b1);
    finish_op("ib", 32'h0104, 5'd1);

    // Backpressure on beat 2, with a stray START while running
    start_op(16'h8005, 32'h1000, 1'b1, 1'b0);
    beat("bp_b1", 4'd0, 32'h1000, 1'b0);
    bus.xfer_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.start   = (i == 1);
      bus.reglist = 16'h0000;
      bus.base    = 32'hDEAD0000;
      check("bp_hold_valid", {31'd0, bus.xfer_valid}, 32'd1);
      check("bp_hold_addr",  {28'd0, bus.addr}, 32'd2);
      check("bp_hold_mem",   bus.mem_addr, 32'h1004);
      check("bp_hold_last",  {31'd0, bus.last}, 32'd0);
      tick();
    end
    bus.start      = 1'b0;
    bus.xfer_ready = 1'b1;
    beat("bp_b2", 4'd2,  32'h1004, 1'b0);
    beat("bp_b3", 4'd15, 32'h1008, 1'b1);
    finish_op("bp", 32'h100C, 5'd3);

    // Empty list
    start_op(16'h0000, 32'h12345678, 1'b1, 1'b0);
    finish_op("empty", 32'h12345678, 5'd0);

    // Full list with address wrap
    start_op(16'hFFFF, 32'hFFFFFFF8, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      beat("wrap", 4'(i), 32'hFFFFFFF8 + 32'(4 * i), (i == 15));
    finish_op("wrap", 32'h00000038, 5'd16);

    // Reset in the middle of a sequence
    start_op(16'h8005, 32'h1000, 1'b1, 1'b0);
    beat("mrst_b1", 4'd0, 32'h1000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, bus.xfer_valid}, 32'd0);
    check("mrst_busy",  {31'd0, bus.busy}, 32'd0);
    check("mrst_mem",   bus.mem_addr, 32'd0);
    check("mrst_wb",    bus.wb_addr, 32'd0);
    check("mrst_count", {27'd0, bus.count}, 32'd0);
    tick();
    check("mrst_nodone", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mrst_nodone2", {31'd0, bus.done}, 32'd0);
    check("mrst_idle",    {31'd0, bus.busy}, 32'd0);

`ifdef REGLIST_SEQ_ABORT_EN
    // Abort on beat 2 without a handshake
    start_op(16'h8005, 32'h1000, 1'b1, 1'b0);
    beat("ab_b1", 4'd0, 32'h1000, 1'b0);
    bus.abort      = 1'b1;
    bus.xfer_ready = 1'b0;
    tick();
    bus.abort      = 1'b0;
    bus.xfer_ready = 1'b1;
    check("ab_aborted", {31'd0, bus.aborted}, 32'd1);
    finish_op("ab", 32'h100C, 5'd3);
    check("ab_aborted0", {31'd0, bus.aborted}, 32'd0);

    // Abort coinciding with the final handshake
    start_op(16'h0001, 32'h0200, 1'b1, 1'b0);
    bus.abort = 1'b1;
    beat("abl_b1", 4'd0, 32'h0200, 1'b1);
    bus.abort = 1'b0;
    check("abl_aborted", {31'd0, bus.aborted}, 32'd1);
    finish_op("abl", 32'h0204, 5'd1);

    // Normal completion does not flag an abort
    start_op(16'h0001, 32'h0300, 1'b1, 1'b0);
    beat("nab_b1", 4'd0, 32'h0300, 1'b1);
    check("nab_aborted", {31'd0, bus.aborted}, 32'd0);
    finish_op("nab", 32'h0304, 5'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reglist_seq.md
# reglist_seq

Register-list sequencer for LDM/STM block transfers. Walks a 16-bit register list lowest-first and drives the 4-bit select of the 16:1 register read mux, one register per beat. Generates the matching word address for each beat and the final writeback base. Sits between the instruction decoder and the register-file read port / load-store unit.

## Interface
- BITWIDTH, 32: width of base, memory address and writeback address.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  begin a block transfer; sampled only in IDLE.
- REGLIST  in  16  register list, bit i = Ri; sampled with START.
- BASE  in  BITWIDTH  base register value; sampled with START.
- UP  in  1  1 = increment (IA/IB), 0 = decrement (DA/DB); sampled with START.
- PRE  in  1  1 = pre-index (IB/DB), 0 = post-index (IA/DA); sampled with START.
- BUSY  out  1  high in RUN and DONE states.
- ADDR  out  4  register index for the read mux; valid while XFER_VALID, else 0.
- MEM_ADDR  out  BITWIDTH  word address of the current beat; valid while XFER_VALID, else 0.
- XFER_VALID  out  1  beat offered.
- XFER_READY  in  1  beat accepted when XFER_VALID && XFER_READY.
- LAST  out  1  current beat is the final one; qualified by XFER_VALID.
- DONE  out  1  one-cycle pulse at end of sequence.
- WB_ADDR  out  BITWIDTH  writeback base, BASE ± 4*COUNT; valid while DONE, else holds.
- COUNT  out  5  population count of the latched REGLIST (0..16).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: on START, latch REGLIST into the remaining mask, compute COUNT = popcount(REGLIST), and compute the start address:
  - UP=1,PRE=0: BASE
  - UP=1,PRE=1: BASE+4
  - UP=0,PRE=0: BASE−4*COUNT+4
  - UP=0,PRE=1: BASE−4*COUNT
- WB_ADDR = BASE+4*COUNT (UP=1) or BASE−4*COUNT (UP=0).
- START with REGLIST≠0 → RUN; START with REGLIST=0 → DONE directly, with no beats, COUNT=0 and WB_ADDR=BASE.
- RUN: ADDR = index of the lowest set bit of the remaining mask, and XFER_VALID=1.
  - Registers always go in ascending index at ascending address.
  - LAST=1 when the mask has exactly one bit set.
  - On handshake: clear that bit and add 4 to MEM_ADDR.
  - On the handshake with LAST=1 → DONE.
- No handshake: ADDR, MEM_ADDR, LAST and the mask hold unchanged.
- DONE: DONE=1 for exactly one cycle, then → IDLE.
- START outside IDLE is ignored. REGLIST, BASE, UP and PRE are don't-care outside the START cycle.
- All address arithmetic is modulo 2^BITWIDTH; wrap-around is silent.
- Reset values: BUSY=0, ADDR=0, MEM_ADDR=0, XFER_VALID=0, LAST=0, DONE=0, WB_ADDR=0, COUNT=0, mask=0.
- RST_N low mid-sequence aborts immediately to IDLE with reset values; no DONE is produced.

## Timing
- First XFER_VALID appears the cycle after START is sampled.
- With XFER_READY held high, an N-register list takes N consecutive beats.
- DONE is asserted the cycle after the last handshake, so START→DONE is N+1 cycles.
- Empty list: DONE is asserted the cycle after START.
- Earliest next START is accepted the cycle after DONE (back in IDLE).
- Outputs are registered or decoded from registers only; there is no combinational path from START/REGLIST/XFER_READY to any output.

## Configuration
- REGLIST_SEQ_ABORT_EN:
  - Defined: adds input ABORT (1) and output ABORTED (1, reset 0).
    - ABORT high in RUN at a clock edge → DONE next cycle, regardless of XFER_READY; no further beats.
    - ABORTED=1 together with DONE; WB_ADDR unchanged (still the full-list value); the mask is cleared.
    - ABORT in the same cycle as the LAST handshake: the handshake completes and ABORTED=1.
    - ABORT is ignored in IDLE and DONE.
  - Undefined: neither port exists and sequences always run to completion.

## Test plan
- Reset: hold RST_N low with random inputs → every output 0; release → IDLE, BUSY=0.
- IA: REGLIST=16'h8005, BASE=0x1000, UP=1, PRE=0, READY=1 → beats (ADDR,MEM_ADDR) = (0,0x1000), (2,0x1004), (15,0x1008); LAST on the 3rd; DONE next cycle with WB_ADDR=0x100C, COUNT=3.
- DB: REGLIST=16'h00F0, BASE=0x2000, UP=0, PRE=1 → ADDR 4..7 at 0x1FF0, 0x1FF4, 0x1FF8, 0x1FFC; WB_ADDR=0x1FF0.
- Backpressure: case 2 with XFER_READY low for 3 cycles on beat 2 → ADDR=2 and MEM_ADDR=0x1004 held, no skipped or duplicated beat; START pulsed during RUN is ignored.
- Empty list and wrap: REGLIST=0 → DONE one cycle after START, no XFER_VALID, WB_ADDR=BASE. REGLIST=16'hFFFF, BASE=0xFFFFFFF8, UP=1, PRE=0 → MEM_ADDR wraps to 0 on beat 3, WB_ADDR=0x38.
- Mid-op reset / abort: RST_N low during beat 2 → immediate IDLE, no DONE. With REGLIST_SEQ_ABORT_EN, ABORT during beat 2 → DONE and ABORTED the next cycle, no beat 3.
